// File: rtl/itq_pkg.sv
// Shared constants and types for the transform/quantisation reconstruction path.
// Holds the DCT shift-add constants, accumulator width and residual vector type.
package itq_pkg;

  localparam int C64   = 64;
  localparam int C83   = 83;
  localparam int C36   = 36;
  localparam int ACC_W = 25;
  localparam int RES_W = 16;

  typedef struct packed {
    logic signed [RES_W-1:0] r0;
    logic signed [RES_W-1:0] r1;
    logic signed [RES_W-1:0] r2;
    logic signed [RES_W-1:0] r3;
  } res_vec_t;

endpackage

// File: rtl/spiral_idct4.sv
// Combinational shift-add constant multiplier: x*36, x*64, x*83 (no multipliers).
// Ports: x (IW signed) in; m36, m64, m83 (PW signed) out.
module spiral_idct4 #(
  parameter int IW = 16,
  parameter int PW = IW + 7
) (
  input  logic signed [IW-1:0] x,
  output logic signed [PW-1:0] m36,
  output logic signed [PW-1:0] m64,
  output logic signed [PW-1:0] m83
);

  logic signed [PW-1:0] xe;

  assign xe  = {{(PW-IW){x[IW-1]}}, x};
  assign m64 = xe <<< 6;
  assign m36 = (xe <<< 5) + (xe <<< 2);
  assign m83 = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;

endmodule

// File: rtl/itq_idct4_serial.sv
// Serial-in / parallel-out 4-point inverse DCT with round-and-shift output.
// Ports: clk, rst (async high); i_valid/i_ready/i_data coefficient stream
// (c0..c3); o_valid/o_ready/o_data_0..3 residual vector.
// IDCT4_CLIP_EN defined: saturate results to OW bits; else wrap to OW bits.
module itq_idct4_serial
  import itq_pkg::*;
#(
  parameter int SHIFT = 7,
  parameter int IW    = 16,
  parameter int OW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic signed [IW-1:0] i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic signed [OW-1:0] o_data_0,
  output logic signed [OW-1:0] o_data_1,
  output logic signed [OW-1:0] o_data_2,
  output logic signed [OW-1:0] o_data_3
);

  localparam int PW = IW + 7;
  localparam int RW = ACC_W + 2;
  localparam logic signed [RW-1:0] RND  = RW'(1 << (SHIFT - 1));
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = -RW'(1 << (OW - 1));

  logic        [1:0]       cnt;
  logic signed [ACC_W-1:0] e0, e1, o0, o1;
  logic signed [PW-1:0]    p36, p64, p83;
  logic signed [ACC_W-1:0] a36, a64, a83;
  logic signed [ACC_W-1:0] o0f, o1f;
  logic signed [RW-1:0]    s0, s1, s2, s3;
  logic                    fire, last;

  spiral_idct4 #(.IW(IW), .PW(PW)) u_mul (
    .x   (i_data),
    .m36 (p36),
    .m64 (p64),
    .m83 (p83)
  );

  assign a36 = ACC_W'(p36);
  assign a64 = ACC_W'(p64);
  assign a83 = ACC_W'(p83);

  // Stall only the completing beat, and only if the held vector cannot drain.
  assign i_ready = !(cnt == 2'd3 && o_valid && !o_ready);
  assign fire    = i_valid && i_ready;
  assign last    = fire && cnt == 2'd3;

  // Final odd terms are formed on the fly during beat 3.
  assign o0f = o0 + a36;
  assign o1f = o1 - a83;

  assign s0 = RW'(e0) + RW'(o0f);
  assign s1 = RW'(e1) + RW'(o1f);
  assign s2 = RW'(e1) - RW'(o1f);
  assign s3 = RW'(e0) - RW'(o0f);

  function automatic logic signed [OW-1:0] narrow(
    input logic signed [RW-1:0] r
  );
    logic signed [RW-1:0] t;
    t = (r + RND) >>> SHIFT;
`ifdef IDCT4_CLIP_EN
    if (t > MAXV)      narrow = OW'(MAXV);
    else if (t < MINV) narrow = OW'(MINV);
    else               narrow = OW'(t);
`else
    narrow = OW'(t);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      e0  <= '0;
      e1  <= '0;
      o0  <= '0;
      o1  <= '0;
    end else if (fire) begin
      cnt <= cnt + 2'd1;
      unique case (cnt)
        2'd0: begin
          e0 <= a64;
          e1 <= a64;
        end
        2'd1: begin
          o0 <= a83;
          o1 <= a36;
        end
        2'd2: begin
          e0 <= e0 + a64;
          e1 <= e1 - a64;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_data_0 <= '0;
      o_data_1 <= '0;
      o_data_2 <= '0;
      o_data_3 <= '0;
    end else if (last) begin
      o_valid  <= 1'b1;
      o_data_0 <= narrow(s0);
      o_data_1 <= narrow(s1);
      o_data_2 <= narrow(s2);
      o_data_3 <= narrow(s3);
    end else if (o_ready) begin
      o_valid  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  initial assert (MAXV > 0);
`endif

endmodule

// File: tb/tb_itq_idct4_serial.sv
// Scoreboard bench for itq_idct4_serial (SHIFT=7, IW=OW=16).
// Directed vectors push expected residuals; a monitor checks each output handshake.
module tb_itq_idct4_serial;
  import itq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               i_ready;
  logic signed [15:0] i_data;
  logic               o_valid;
  logic               o_ready;
  logic signed [15:0] o_data_0, o_data_1, o_data_2, o_data_3;

  int tests = 0;
  int fails = 0;
  res_vec_t exp_q[$];

  itq_idct4_serial #(.SHIFT(7), .IW(16), .OW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data_0 (o_data_0),
    .o_data_1 (o_data_1),
    .o_data_2 (o_data_2),
    .o_data_3 (o_data_3)
  );

  always #5 clk = ~clk;

  function automatic res_vec_t mk(input int a, input int b,
                                  input int c, input int d);
    res_vec_t v;
    v.r0 = 16'(a);
    v.r1 = 16'(b);
    v.r2 = 16'(c);
    v.r3 = 16'(d);
    return v;
  endfunction

  function automatic res_vec_t cur();
    return mk(int'(o_data_0), int'(o_data_1),
              int'(o_data_2), int'(o_data_3));
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input res_vec_t act,
                           input res_vec_t req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got [%0d %0d %0d %0d] expected [%0d %0d %0d %0d]",
               name, act.r0, act.r1, act.r2, act.r3,
               req.r0, req.r1, req.r2, req.r3);
    end
  endtask

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check_vec("scoreboard", cur(), exp_q.pop_front());
      end
    end
  end

  task automatic send(input int d, input int gap);
    bit ok;
    int n;
    i_valid = 1'b1;
    i_data  = 16'(d);
    n = 0;
    do begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("i_ready_timeout", 0, 1);
    i_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_vec(input int c0, input int c1, input int c2,
                          input int c3, input int gap, input res_vec_t e);
    exp_q.push_back(e);
    send(c0, gap);
    send(c1, gap);
    send(c2, gap);
    send(c3, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  res_vec_t dc_e, odd_e, ovf_e, held;

  initial begin
    dc_e  = mk(32, 32, 32, 32);
    odd_e = mk(83, 36, -36, -83);
`ifdef IDCT4_CLIP_EN
    ovf_e = mk(32767, -12032, 12032, 2304);
`else
    ovf_e = mk(-2306, -12032, 12032, 2304);
`endif
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("reset_o_valid", int'(o_valid), 0);
    check_vec("reset_o_data", cur(), mk(0, 0, 0, 0));
    check("reset_i_ready", int'(i_ready), 1);
    @(posedge clk);
    #1;

    // DC vector and single-cycle latency
    send(64, 0);
    send(0, 0);
    send(0, 0);
    check("dc_valid_before", int'(o_valid), 0);
    exp_q.push_back(dc_e);
    send(0, 0);
    check("dc_latency", int'(o_valid), 1);

    // Back-to-back vectors: odd basis then overflow, no bubbles
    send_vec(0, 128, 0, 0, 0, odd_e);
    send_vec(32767, 32767, 32767, 32767, 0, ovf_e);
    repeat (3) @(posedge clk);
    #1;
    check("idle_o_valid", int'(o_valid), 0);

    // Backpressure: second vector's beat3 stalls while first is held
    o_ready = 1'b0;
    send_vec(64, 0, 0, 0, 0, dc_e);
    exp_q.push_back(odd_e);
    send(0, 0);
    send(128, 0);
    send(0, 0);
    i_valid = 1'b1;
    i_data  = 16'sd0;
    repeat (3) begin
      @(negedge clk);
      check("bp_i_ready_low", int'(i_ready), 0);
      check_vec("bp_hold", cur(), dc_e);
      @(posedge clk);
      #1;
    end
    o_ready = 1'b1;
    @(negedge clk);
    check("bp_i_ready_comb", int'(i_ready), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("bp_second_valid", int'(o_valid), 1);
    check_vec("bp_second_data", cur(), odd_e);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-vector discards the partial vector
    send(1000, 0);
    send(-2000, 0);
    do_reset();
    @(negedge clk);
    check("midrst_o_valid", int'(o_valid), 0);
    @(posedge clk);
    #1;
    send_vec(64, 0, 0, 0, 0, dc_e);

    // Gapped input: three idle cycles between beats
    send_vec(0, 128, 0, 0, 3, odd_e);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
